argmax_pipe_selector: RTL and testbench

//   Parametrised, pipelined successor of the fixed 10-input max selector at the classifier output.

---
 rtl/argmax_pipe_selector.sv | 94 +++++++++
 tb/tb_argmax_pipe_selector.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_pipe_selector.sv
// rtl/argmax_pipe_selector.sv - pipelined tournament-tree argmax with valid/ready handshake
// Stage 0 registers the raw vector; each later stage halves the candidate count.
module argmax_pipe_selector #(
  parameter int N_CH   = 10,
  parameter int WIDTH  = 26,
  parameter bit SIGNED = 1'b1
) (
  input  logic                                          clk,
  input  logic                                          GlobalReset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [N_CH*WIDTH-1:0]                         in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    out_idx,
  output logic [WIDTH-1:0]                              out_max
);

  localparam int L     = $clog2(N_CH);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Number of live candidates held at tree level lvl.
  function automatic int cnt_at(input int lvl);
    return (N_CH + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic b_gt_a(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] a);
    if (SIGNED) return $signed(b) > $signed(a);
    else        return b > a;
  endfunction

  logic [WIDTH-1:0] val_q [0:L][0:N_CH-1];
  logic [WIDTH-1:0] val_d [0:L][0:N_CH-1];
  logic [IDX_W-1:0] idx_q [0:L][0:N_CH-1];
  logic [IDX_W-1:0] idx_d [0:L][0:N_CH-1];
  logic [L:0]       vld_q;
  logic [L:0]       vld_d;
  logic             adv;

  always_comb begin
    adv   = !vld_q[L] || out_ready;
    val_d = val_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int k = 0; k < N_CH; k++) begin
        val_d[0][k] = in_data[k*WIDTH +: WIDTH];
        idx_d[0][k] = IDX_W'(k);
      end
      for (int l = 1; l <= L; l++) begin
        vld_d[l] = vld_q[l-1];
        for (int j = 0; j < N_CH; j++) begin
          // The lower-index element (a) keeps ties; an unpaired element passes straight through.
          if (j < cnt_at(l)) begin
            if ((2*j + 1 < cnt_at(l-1)) &&
                b_gt_a(val_q[l-1][(2*j + 1) % N_CH], val_q[l-1][(2*j) % N_CH])) begin
              val_d[l][j] = val_q[l-1][(2*j + 1) % N_CH];
              idx_d[l][j] = idx_q[l-1][(2*j + 1) % N_CH];
            end else begin
              val_d[l][j] = val_q[l-1][(2*j) % N_CH];
              idx_d[l][j] = idx_q[l-1][(2*j) % N_CH];
            end
          end else begin
            val_d[l][j] = '0;
            idx_d[l][j] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      vld_q <= '0;
      for (int l = 0; l <= L; l++) begin
        for (int k = 0; k < N_CH; k++) begin
          val_q[l][k] <= '0;
          idx_q[l][k] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      val_q <= val_d;
      idx_q <= idx_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[L];
  assign out_idx   = idx_q[L][0];
  assign out_max   = val_q[L][0];

endmodule

// File: tb/tb_argmax_pipe_selector.sv
// tb/tb_argmax_pipe_selector.sv - scoreboard bench for argmax_pipe_selector (signed and unsigned copies)
module tb_argmax_pipe_selector;

  localparam int NC = 10;
  localparam int W  = 26;
  localparam int LAT = 5;

  logic            clk = 1'b0;
  logic            GlobalReset;
  logic            in_valid;
  logic [NC*W-1:0] in_data;
  logic            out_ready;
  logic            in_ready_s, in_ready_u;
  logic            out_valid_s, out_valid_u;
  logic [3:0]      out_idx_s, out_idx_u;
  logic [W-1:0]    out_max_s, out_max_u;

  argmax_pipe_selector #(.N_CH(NC), .WIDTH(W), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_idx(out_idx_s), .out_max(out_max_s));

  argmax_pipe_selector #(.N_CH(NC), .WIDTH(W), .SIGNED(1'b0)) u_uns (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_idx(out_idx_u), .out_max(out_max_u));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx_s;
    logic [W-1:0] max_s;
    logic [3:0]   idx_u;
    logic [W-1:0] max_u;
    int           t_acc;
    int           st_acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   stall_left = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Linear scan: first channel holding the strictly largest value wins.
  function automatic void ref_max(input logic [NC*W-1:0] v, input bit sgn,
                                  output logic [3:0] idx, output logic [W-1:0] mx);
    logic [W-1:0] c;
    idx = 4'd0;
    mx  = v[W-1:0];
    for (int k = 1; k < NC; k++) begin
      c = v[k*W +: W];
      if (sgn ? ($signed(c) > $signed(mx)) : (c > mx)) begin
        idx = 4'(k);
        mx  = c;
      end
    end
  endfunction

  function automatic logic [NC*W-1:0] fill(input logic [W-1:0] base);
    logic [NC*W-1:0] v;
    for (int k = 0; k < NC; k++) v[k*W +: W] = base;
    return v;
  endfunction

  function automatic logic [NC*W-1:0] rand_vec();
    logic [NC*W-1:0] v;
    logic [W-1:0] c;
    for (int k = 0; k < NC; k++) begin
      case ($urandom % 3)
        0: c = W'($urandom);
        1: case ($urandom % 4)
             0: c = '0;
             1: c = 26'd5;
             2: c = 26'h3FFFFFF;
             default: c = 26'h2000000;
           endcase
        default: c = (k == 0) ? W'($urandom) : v[W-1:0];
      endcase
      v[k*W +: W] = c;
    end
    return v;
  endfunction

  // out_ready driver: directed stalls take priority over random throttling.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      out_ready = rand_rdy ? ($urandom % 4 != 0) : 1'b1;
    end
  end

  task automatic send(input logic [NC*W-1:0] v);
    exp_t e;
    bit   acc;
    int   guard;
    in_data  = v;
    in_valid = 1'b1;
    ref_max(v, 1'b1, e.idx_s, e.max_s);
    ref_max(v, 1'b0, e.idx_u, e.max_u);
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready_s;
      if (acc) begin
        e.t_acc  = cyc;
        e.st_acc = stalls;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = rand_vec();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on each output handshake, plus hold and in_ready checks.
  bit           hold_pend = 1'b0;
  logic [3:0]   hold_idx_s;
  logic [W-1:0] hold_max_s;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!GlobalReset) begin
        hold_pend = 1'b0;
      end else begin
        chk("in_ready_s_rule", in_ready_s, !out_valid_s || out_ready);
        chk("in_ready_u_rule", in_ready_u, !out_valid_u || out_ready);
        if (hold_pend) begin
          chk("hold_valid", out_valid_s, 1'b1);
          chk("hold_idx", out_idx_s, hold_idx_s);
          chk("hold_max", out_max_s, hold_max_s);
        end
        if ((out_valid_s || out_valid_u) && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got out_valid s=%0b u=%0b expected none", out_valid_s, out_valid_u);
          end else begin
            e = exp_q.pop_front();
            chk("valid_s", out_valid_s, 1'b1);
            chk("valid_u", out_valid_u, 1'b1);
            chk("idx_s", out_idx_s, e.idx_s);
            chk("max_s", out_max_s, e.max_s);
            chk("idx_u", out_idx_u, e.idx_u);
            chk("max_u", out_max_u, e.max_u);
            chk("latency", cyc, e.t_acc + LAT + (stalls - e.st_acc));
          end
        end
        hold_pend  = out_valid_s && !out_ready;
        hold_idx_s = out_idx_s;
        hold_max_s = out_max_s;
        if (out_valid_s && !out_ready) stalls++;
      end
    end
  end

  initial begin
    logic [NC*W-1:0] v;
    int cnt;
    int guard;
    GlobalReset = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid_s, 1'b0);
      chk("rst_idx", out_idx_s, 4'd0);
      chk("rst_max", out_max_s, 26'd0);
    end
    @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_s", in_ready_s, 1'b1);
    chk("rst_in_ready_u", in_ready_u, 1'b1);
    chk("rst_valid_u", out_valid_u, 1'b0);
    @(posedge clk);
    #1;

    // Basic: single winner, exactly one output cycle
    v = fill(26'd5);
    v[7*W +: W] = 26'd1000;
    send(v);
    idle();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_s) cnt++;
    end
    chk("basic_one_cycle", cnt, 1);
    @(posedge clk);
    #1;

    // Sign and tie cases
    v = fill(26'h3FFFFFB);
    v[3*W +: W] = 26'h3FFFFFF;
    send(v);
    v = fill(26'd0);
    v[2*W +: W] = 26'd500;
    v[8*W +: W] = 26'd500;
    send(v);
    v = fill(26'd0);
    v[0 +: W] = 26'h3FFFFFF;
    v[W +: W] = 26'd1;
    send(v);
    idle();

    // Streaming 20 vectors with a 3-cycle backpressure window
    for (int i = 0; i < 20; i++) begin
      v = '0;
      for (int k = 0; k < NC; k++) v[k*W +: W] = W'($urandom % 100);
      v[(i % NC)*W +: W] = W'(i + 100);
      if (i == 8) stall_left = 3;
      send(v);
    end
    idle();
    for (int i = 0; i < 10; i++) idle();

    // Mid-operation reset with 3 vectors in flight
    for (int i = 0; i < 3; i++) send(rand_vec());
    in_valid = 1'b0;
    GlobalReset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_valid_s", out_valid_s, 1'b0);
      chk("midrst_valid_u", out_valid_u, 1'b0);
    end
    @(posedge clk);
    #1;
    send(rand_vec());
    idle();

    // Randomized traffic with random out_ready and input gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom % 4 == 0) idle();
      send(rand_vec());
    end
    idle();
    rand_rdy = 1'b0;

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
